// File: rtl/bp_stream_to_lite_pkg.sv
// Shared BedRock field widths, message encodings and helpers for the
// stream-to-lite gatherer.
package bp_stream_to_lite_pkg;

  localparam int unsigned msg_type_width_gp = 4;
  localparam int unsigned subop_width_gp    = 4;
  localparam int unsigned msg_size_width_gp = 3;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  // Index width that never collapses to zero bits for a single element.
  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 32'd1) ? 32'd1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bp_stream_to_lite_chk.sv
// Simulation checker for the incoming stream protocol: last-beat position,
// header consistency across beats and width legality.
module bp_stream_to_lite_chk
  import bp_stream_to_lite_pkg::*;
#(
  parameter int unsigned paddr_width_p    = 40,
  parameter int unsigned payload_width_p  = 16,
  parameter int unsigned in_data_width_p  = 64,
  parameter int unsigned out_data_width_p = 512,
  parameter logic [15:0] payload_mask_p   = 16'h0000,
  localparam int unsigned hdr_width_lp = msg_type_width_gp + subop_width_gp
                                       + paddr_width_p + msg_size_width_gp + payload_width_p
) (
  input logic                    clk_i,
  input logic                    reset_i,
  input logic [hdr_width_lp-1:0] in_msg_header_i,
  input logic                    in_msg_v_i,
  input logic                    in_msg_ready_and_i,
  input logic                    in_msg_last_i
);

  localparam int unsigned addr_lsb_lp = msg_type_width_gp + subop_width_gp;
  localparam int unsigned size_lsb_lp = addr_lsb_lp + paddr_width_p;
  localparam int unsigned in_bytes_lp = in_data_width_p / 8;
  localparam logic [hdr_width_lp-1:0] addr_mask_lp =
    {{(hdr_width_lp-size_lsb_lp){1'b0}}, {paddr_width_p{1'b1}}, {addr_lsb_lp{1'b0}}};

  logic [31:0]             beat_q, beat_d;
  logic [hdr_width_lp-1:0] first_hdr_q, first_hdr_d;
  logic                    fire_s;
  logic [3:0]              msg_type_s;
  logic [2:0]              size_s;
  logic [31:0]             exp_beats_s;

  assign fire_s     = in_msg_v_i & in_msg_ready_and_i;
  assign msg_type_s = in_msg_header_i[3:0];
  assign size_s     = in_msg_header_i[size_lsb_lp +: msg_size_width_gp];

  // Legal beat count of the message whose header is on the input.
  always_comb begin
    if (!payload_mask_p[msg_type_s]) begin
      exp_beats_s = 32'd1;
    end else if (((32'd1 << size_s) / in_bytes_lp) == 32'd0) begin
      exp_beats_s = 32'd1;
    end else begin
      exp_beats_s = (32'd1 << size_s) / in_bytes_lp;
    end
  end

  // Beat index and first-header tracking.
  always_comb begin
    beat_d      = beat_q;
    first_hdr_d = first_hdr_q;
    if (fire_s) begin
      beat_d = in_msg_last_i ? 32'd0 : (beat_q + 32'd1);
      if (beat_q == 32'd0) begin
        first_hdr_d = in_msg_header_i;
      end else begin
        first_hdr_d = first_hdr_q;
      end
    end else begin
      beat_d = beat_q;
    end
  end

  // Tracking registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      beat_q      <= 32'd0;
      first_hdr_q <= '0;
    end else begin
      beat_q      <= beat_d;
      first_hdr_q <= first_hdr_d;
    end
  end

  // Protocol assertions.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert ((in_data_width_p <= out_data_width_p) && ((out_data_width_p % in_data_width_p) == 0));
      if (fire_s) begin
        assert (in_msg_last_i == ((beat_q + 32'd1) == exp_beats_s));
        if (beat_q != 32'd0) begin
          assert (((in_msg_header_i ^ first_hdr_q) & ~addr_mask_lp) == '0);
        end
      end
    end
  end

endmodule

// File: rtl/bp_stream_to_lite_slot_demux.sv
// One-hot write-enable decoder for the data slots of the wide Lite word;
// replication opens every slot at once.
module bp_stream_to_lite_slot_demux #(
  parameter int unsigned els_p    = 8,
  parameter int unsigned lg_els_p = 3
) (
  input  logic                v_i,
  input  logic                replicate_i,
  input  logic [lg_els_p-1:0] slot_i,
  output logic [els_p-1:0]    en_o
);

  // Per-slot enable decode.
  always_comb begin
    en_o = '0;
    for (int i = 0; i < els_p; i++) begin
      if (v_i && (replicate_i || (slot_i == lg_els_p'(i)))) begin
        en_o[i] = 1'b1;
      end else begin
        en_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bp_stream_to_lite.sv
// Gathers a multi-beat BedRock Stream message into one wide BedRock Lite
// message, placing beats by critical-word address with wrap-around.
module bp_stream_to_lite
  import bp_stream_to_lite_pkg::*;
#(
  parameter int unsigned paddr_width_p    = 40,
  parameter int unsigned payload_width_p  = 16,
  parameter int unsigned in_data_width_p  = 64,
  parameter int unsigned out_data_width_p = 512,
  parameter logic [15:0] payload_mask_p   = 16'h0000,
  localparam int unsigned in_msg_header_width_lp = msg_type_width_gp + subop_width_gp
                                                 + paddr_width_p + msg_size_width_gp + payload_width_p,
  localparam int unsigned out_msg_width_lp = in_msg_header_width_lp + out_data_width_p
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [in_msg_header_width_lp-1:0] in_msg_header_i,
  input  logic [in_data_width_p-1:0]        in_msg_data_i,
  input  logic                              in_msg_v_i,
  output logic                              in_msg_ready_and_o,
  input  logic                              in_msg_last_i,
  output logic [out_msg_width_lp-1:0]       out_msg_o,
  output logic                              out_msg_v_o,
  input  logic                              out_msg_ready_and_i
);

  localparam int unsigned beats_lp      = out_data_width_p / in_data_width_p;
  localparam int unsigned offset_lp     = $clog2(in_data_width_p / 8);
  localparam int unsigned slot_width_lp = safe_clog2(beats_lp);
  localparam int unsigned addr_lsb_lp   = msg_type_width_gp + subop_width_gp;
  localparam int unsigned size_lsb_lp   = addr_lsb_lp + paddr_width_p;

  typedef enum logic {
    e_gather = 1'b0,
    e_send   = 1'b1
  } state_e;

  state_e                            state_q, state_d;
  logic [slot_width_lp-1:0]          cnt_q, cnt_d;
  logic [slot_width_lp-1:0]          first_slot_q, first_slot_d;
  logic [in_msg_header_width_lp-1:0] header_q, header_d;
  logic [out_data_width_p-1:0]       data_q, data_d;

  logic                     in_fire_s;
  logic                     out_fire_s;
  logic                     first_beat_s;
  logic [3:0]               msg_type_s;
  logic [2:0]               size_s;
  logic                     has_data_s;
  logic                     replicate_s;
  logic [slot_width_lp-1:0] first_slot_s;
  logic [slot_width_lp-1:0] slot_s;
  logic [beats_lp-1:0]      slot_en_s;

  assign in_msg_ready_and_o = (state_q == e_gather);
  assign out_msg_v_o        = (state_q == e_send);
  assign out_msg_o          = {header_q, data_q};

  assign in_fire_s    = in_msg_v_i & in_msg_ready_and_o;
  assign out_fire_s   = out_msg_v_o & out_msg_ready_and_i;
  assign first_beat_s = (cnt_q == '0);

  // Non-first beats repeat the first header apart from addr, so the live
  // header is good enough for type and size decisions.
  assign msg_type_s  = in_msg_header_i[3:0];
  assign size_s      = in_msg_header_i[size_lsb_lp +: msg_size_width_gp];
  assign has_data_s  = payload_mask_p[msg_type_s];
  assign replicate_s = has_data_s && (32'(size_s) <= offset_lp);

  assign first_slot_s = first_beat_s ? in_msg_header_i[addr_lsb_lp + offset_lp +: slot_width_lp]
                                     : first_slot_q;
  assign slot_s = (beats_lp == 1) ? {slot_width_lp{1'b0}} : (first_slot_s + cnt_q);

  bp_stream_to_lite_slot_demux #(
    .els_p    (beats_lp),
    .lg_els_p (slot_width_lp)
  ) slot_demux (
    .v_i         (in_fire_s & has_data_s),
    .replicate_i (replicate_s),
    .slot_i      (slot_s),
    .en_o        (slot_en_s)
  );

  // Gather/send sequencing, beat counter and first-beat capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    header_d     = header_q;
    first_slot_d = first_slot_q;
    case (state_q)
      e_gather: begin
        if (in_fire_s) begin
          if (first_beat_s) begin
            header_d     = in_msg_header_i;
            first_slot_d = first_slot_s;
          end else begin
            header_d     = header_q;
            first_slot_d = first_slot_q;
          end
          if (in_msg_last_i) begin
            cnt_d   = {slot_width_lp{1'b0}};
            state_d = e_send;
          end else begin
            cnt_d   = cnt_q + slot_width_lp'(1'b1);
            state_d = e_gather;
          end
        end else begin
          state_d = e_gather;
        end
      end
      e_send: begin
        if (out_fire_s) begin
          state_d = e_gather;
        end else begin
          state_d = e_send;
        end
      end
      default: begin
        state_d = e_gather;
      end
    endcase
  end

  // Slot writes; the first beat also clears stale slots so no-data
  // messages present zero and nothing leaks from an earlier message.
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < beats_lp; i++) begin
      if (slot_en_s[i]) begin
        data_d[i*in_data_width_p +: in_data_width_p] = in_msg_data_i;
      end else if (in_fire_s && first_beat_s) begin
        data_d[i*in_data_width_p +: in_data_width_p] = '0;
      end else begin
        data_d[i*in_data_width_p +: in_data_width_p] = data_q[i*in_data_width_p +: in_data_width_p];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= e_gather;
      cnt_q        <= {slot_width_lp{1'b0}};
      first_slot_q <= {slot_width_lp{1'b0}};
      header_q     <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      first_slot_q <= first_slot_d;
      header_q     <= header_d;
      data_q       <= data_d;
    end
  end

  bp_stream_to_lite_chk #(
    .paddr_width_p    (paddr_width_p),
    .payload_width_p  (payload_width_p),
    .in_data_width_p  (in_data_width_p),
    .out_data_width_p (out_data_width_p),
    .payload_mask_p   (payload_mask_p)
  ) chk (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .in_msg_header_i    (in_msg_header_i),
    .in_msg_v_i         (in_msg_v_i),
    .in_msg_ready_and_i (in_msg_ready_and_o),
    .in_msg_last_i      (in_msg_last_i)
  );

endmodule

// File: tb/tb_bp_stream_to_lite.sv
// Directed and randomized bench for bp_stream_to_lite (64-bit beats into a
// 512-bit Lite word) against a slot-placement reference model.
module tb_bp_stream_to_lite;

  localparam int unsigned HW = 67;
  localparam int unsigned OW = HW + 512;
  localparam logic [15:0] MASK = 16'h000B; // rd, wr and uc_wr carry data

  logic          clk = 1'b0;
  logic          rst;
  logic [HW-1:0] in_hdr;
  logic [63:0]   in_data;
  logic          in_v;
  logic          in_last;
  logic          in_ready;
  logic [OW-1:0] out_msg;
  logic          out_v;
  logic          out_ready;

  int total = 0;
  int bad   = 0;
  logic [63:0]   beats [8];
  logic [OW-1:0] exp_a;

  always #5 clk = ~clk;

  bp_stream_to_lite #(
    .paddr_width_p    (40),
    .payload_width_p  (16),
    .in_data_width_p  (64),
    .out_data_width_p (512),
    .payload_mask_p   (MASK)
  ) dut (
    .clk_i               (clk),
    .reset_i             (rst),
    .in_msg_header_i     (in_hdr),
    .in_msg_data_i       (in_data),
    .in_msg_v_i          (in_v),
    .in_msg_ready_and_o  (in_ready),
    .in_msg_last_i       (in_last),
    .out_msg_o           (out_msg),
    .out_msg_v_o         (out_v),
    .out_msg_ready_and_i (out_ready)
  );

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HW-1:0] make_hdr(input logic [3:0] t, input logic [2:0] sz,
                                             input logic [39:0] a, input logic [15:0] pay);
    return {pay, sz, a, 4'h0, t};
  endfunction

  function automatic int n_beats(input logic [3:0] t, input logic [2:0] sz);
    int b;
    if (!MASK[t]) return 1;
    b = (1 << sz) / 8;
    return (b == 0) ? 1 : b;
  endfunction

  // Reference: beat k lands in 64-bit word ((addr/8)+k) mod 8 of the line.
  function automatic logic [511:0] ref_data(input logic [3:0] t, input logic [2:0] sz, input logic [39:0] a);
    logic [511:0] r;
    int base;
    r = '0;
    if (!MASK[t]) return r;
    if ((1 << sz) <= 8) begin
      for (int i = 0; i < 8; i++) r[i*64 +: 64] = beats[0];
      return r;
    end
    base = int'((a / 40'd8) % 40'd8);
    for (int k = 0; k < n_beats(t, sz); k++) r[((base + k) % 8)*64 +: 64] = beats[k];
    return r;
  endfunction

  task automatic wait_ready();
    int c = 0;
    while (in_ready !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("in_ready_wait", OW'(in_ready), OW'(1'b1));
  endtask

  task automatic drive_msg(input logic [3:0] t, input logic [2:0] sz, input logic [39:0] a,
                           input logic [15:0] pay, input int gap_max);
    int n = n_beats(t, sz);
    for (int k = 0; k < n; k++) begin
      int g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      in_v = 1'b0;
      repeat (g) @(negedge clk);
      in_v    = 1'b1;
      in_hdr  = make_hdr(t, sz, a + 40'(k*8), pay);
      in_data = beats[k];
      in_last = (k == n - 1);
      wait_ready();
      @(negedge clk);
    end
    in_v    = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic take_out(input logic [OW-1:0] exp, input int hold, input string tag);
    chk(tag, out_msg, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, out_msg, exp);
      chk({tag, "_hold_flags"}, OW'({out_v, in_ready}), OW'(2'b10));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_after"}, OW'({out_v, in_ready}), OW'(2'b01));
  endtask

  task automatic run_msg(input logic [3:0] t, input logic [2:0] sz, input logic [39:0] a,
                         input logic [15:0] pay, input int gap_max, input int hold, input string tag);
    logic [OW-1:0] exp;
    exp = {make_hdr(t, sz, a, pay), ref_data(t, sz, a)};
    drive_msg(t, sz, a, pay, gap_max);
    chk({tag, "_lat"}, OW'({out_v, in_ready}), OW'(2'b10));
    take_out(exp, hold, tag);
  endtask

  task automatic fill_beats(input logic [31:0] tag);
    for (int k = 0; k < 8; k++) beats[k] = {tag + 32'(k), $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  t;
    logic [2:0]  sz;
    logic [39:0] a;
    int pick;

    rst = 1'b1; in_v = 1'b0; in_last = 1'b0; in_hdr = '0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("reset_flags", OW'({out_v, in_ready}), OW'(2'b01));
    chk("reset_msg", out_msg, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_flags", OW'({out_v, in_ready}), OW'(2'b01));

    // 64B write, line aligned, back-to-back
    fill_beats(32'hD000_0000);
    run_msg(4'd1, 3'd6, 40'h80_0000_0000 >> 8, 16'h1234, 0, 0, "wr64");

    // 64B read response with critical word 3
    fill_beats(32'hE000_0000);
    drive_msg(4'd0, 3'd6, 40'h0080_0000_18, 16'h0042, 0);
    chk("rr_lat", OW'({out_v, in_ready}), OW'(2'b10));
    chk("rr_slot3", OW'(out_msg[3*64 +: 64]), OW'(beats[0]));
    chk("rr_slot7", OW'(out_msg[7*64 +: 64]), OW'(beats[4]));
    chk("rr_slot0", OW'(out_msg[0*64 +: 64]), OW'(beats[5]));
    chk("rr_slot2", OW'(out_msg[2*64 +: 64]), OW'(beats[7]));
    chk("rr_addr", OW'(out_msg[512+8 +: 40]), OW'(40'h0080_0000_18));
    take_out({make_hdr(4'd0, 3'd6, 40'h0080_0000_18, 16'h0042), ref_data(4'd0, 3'd6, 40'h0080_0000_18)}, 1, "rr64");

    // 4B write replicated into every slot
    beats[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    run_msg(4'd3, 3'd2, 40'h104, 16'h0007, 0, 0, "wr4_rep");

    // No-data read command, data ignored
    beats[0] = 64'hDEAD_BEEF_0BAD_F00D;
    run_msg(4'd2, 3'd6, 40'h2000, 16'h00AA, 0, 0, "nodata");

    // Back-pressure with the next message's first beat pending
    fill_beats(32'hB000_0000);
    exp_a = {make_hdr(4'd1, 3'd6, 40'h4000, 16'h0011), ref_data(4'd1, 3'd6, 40'h4000)};
    drive_msg(4'd1, 3'd6, 40'h4000, 16'h0011, 0);
    fill_beats(32'hC000_0000);
    in_v = 1'b1; in_hdr = make_hdr(4'd1, 3'd6, 40'h4028, 16'h0022); in_data = beats[0]; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", out_msg, exp_a);
      chk("bp_flags", OW'({out_v, in_ready}), OW'(2'b10));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release", OW'({out_v, in_ready}), OW'(2'b01));
    run_msg(4'd1, 3'd6, 40'h4028, 16'h0022, 0, 0, "bp_next");

    // Asynchronous reset after 3 of 8 beats
    fill_beats(32'hF000_0000);
    for (int k = 0; k < 3; k++) begin
      in_v = 1'b1; in_hdr = make_hdr(4'd1, 3'd6, 40'h1000 + 40'(k*8), 16'h0033);
      in_data = beats[k]; in_last = 1'b0;
      wait_ready();
      @(negedge clk);
    end
    in_v = 1'b0;
    #2 rst = 1'b1;
    #1 chk("async_rst_flags", OW'({out_v, in_ready}), OW'(2'b01));
    @(negedge clk);
    rst = 1'b0;
    fill_beats(32'h7000_0000);
    run_msg(4'd1, 3'd6, 40'h1028, 16'h0044, 0, 0, "post_abort");

    // Randomized messages with random gaps and back-pressure
    for (int n = 0; n < 40; n++) begin
      t    = 4'($urandom_range(0, 5));
      pick = int'($urandom_range(0, 4));
      sz   = (pick == 4) ? 3'd6 : 3'(pick);
      a    = {8'($urandom), 32'($urandom)};
      fill_beats($urandom);
      run_msg(t, sz, a, 16'($urandom), 2, int'($urandom_range(0, 3)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
